decode_operand_stage: RTL and testbench

//  Decode/operand-fetch stage directly upstream of the 16-bit ALU. Decodes a 16-bit

---
 rtl/decode_operand_stage_if.sv | 34 +++
 rtl/decode_operand_stage.sv | 92 +++++++++
 tb/tb_decode_operand_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/decode_operand_stage_if.sv
// Operand-fetch stage bus: instruction issue, write-back/EX bypass inputs and
// the registered ALU-side slot.
interface decode_operand_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 5
);
  logic              inst_valid;
  logic [15:0]       inst;
  logic              stall;
  logic              flush;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              ex_regwr;
  logic [ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0] ex_result;
  logic [OP_W-1:0]   ALUControl;
  logic [DATA_W-1:0] SrcA;
  logic [DATA_W-1:0] SrcB;
  logic [ADDR_W-1:0] rd_out;
  logic              out_valid;

  modport master (
    output inst_valid, inst, stall, flush, wb_en, wb_addr, wb_data,
           ex_regwr, ex_rd, ex_result,
    input  ALUControl, SrcA, SrcB, rd_out, out_valid
  );
  modport slave (
    input  inst_valid, inst, stall, flush, wb_en, wb_addr, wb_data,
           ex_regwr, ex_rd, ex_result,
    output ALUControl, SrcA, SrcB, rd_out, out_valid
  );
endinterface

// File: rtl/decode_operand_stage.sv
// Decode + register-file read with EX/WB bypass, registered into the slot the
// ALU consumes. Invalid, flushed and unknown-op slots become a CMP bubble.
module decode_operand_stage #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 5
) (
  input logic CLK,
  input logic RST,
  decode_operand_stage_if.slave bus
);
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ADDR_W-1:0] rd;
    logic              vld;
  } slot_t;

  localparam logic [OP_W-1:0] OP_CMP = OP_W'(5'b00100);

  logic [DATA_W-1:0] regs [NREG];
  slot_t             slot, nxt;
  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] ra_v, rb_v;

  // EX result is newer than the WB value, which is newer than the array.
  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] r);
    if (r == '0)                            return '0;
    else if (bus.ex_regwr && bus.ex_rd == r) return bus.ex_result;
    else if (bus.wb_en && bus.wb_addr == r)  return bus.wb_data;
    else                                     return regs[r];
  endfunction

  assign op   = OP_W'(bus.inst[15:11]);
  assign ra_v = rd_val(bus.inst[7:5]);
  assign rb_v = rd_val(bus.inst[4:2]);

  always_comb begin
    nxt     = '0;
    nxt.op  = OP_CMP;
    if (bus.inst_valid) begin
      nxt.op  = op;
      nxt.rd  = bus.inst[10:8];
      nxt.vld = 1'b1;
      case (op)
        5'b00000, 5'b00001: nxt.a = ra_v;
        5'b00100, 5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100,
        5'b01101, 5'b01110, 5'b10000, 5'b10001, 5'b10010, 5'b10011: begin
          nxt.a = ra_v;
          nxt.b = rb_v;
        end
        5'b10100, 5'b10101: begin
          nxt.a = ra_v;
          nxt.b = DATA_W'(bus.inst[4:0]);
        end
        5'b10110, 5'b10111, 5'b00101: begin
          nxt.a = DATA_W'(bus.inst[7:4]);
          nxt.b = DATA_W'(bus.inst[3:0]);
        end
        5'b00110: nxt.b = DATA_W'(bus.inst[7:0]);
        default: begin
          nxt    = '0;
          nxt.op = OP_CMP;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      slot    <= '0;
      slot.op <= OP_CMP;
    end else begin
      if (bus.wb_en && bus.wb_addr != '0) regs[bus.wb_addr] <= bus.wb_data;
      if (bus.flush) begin
        slot    <= '0;
        slot.op <= OP_CMP;
      end else if (!bus.stall) begin
        slot <= nxt;
      end
    end
  end

  assign bus.ALUControl = slot.op;
  assign bus.SrcA       = slot.a;
  assign bus.SrcB       = slot.b;
  assign bus.rd_out     = slot.rd;
  assign bus.out_valid  = slot.vld;
endmodule

// File: tb/tb_decode_operand_stage.sv
// Scoreboard bench: directed scenarios then random traffic against a
// behavioural register-file/decoder model.
module tb_decode_operand_stage;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  decode_operand_stage_if #(.DATA_W(16), .ADDR_W(3), .OP_W(5)) bi ();
  decode_operand_stage #(.DATA_W(16), .NREG(8), .ADDR_W(3), .OP_W(5)) dut (
    .CLK(CLK), .RST(RST), .bus(bi)
  );

  typedef struct packed {
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rd;
    logic        v;
  } exp_t;

  localparam exp_t BUB = '{op: 5'b00100, a: 16'h0, b: 16'h0, rd: 3'd0, v: 1'b0};

  exp_t        expq[$];
  string       nmq[$];
  exp_t        cur;
  logic [15:0] mregs [8];
  int          compared = 0;
  int          mismatched = 0;

  function automatic logic [15:0] mread(input int r);
    if (r == 0) return 16'h0;
    if (bi.ex_regwr && int'(bi.ex_rd) == r) return bi.ex_result;
    if (bi.wb_en && int'(bi.wb_addr) == r) return bi.wb_data;
    return mregs[r];
  endfunction

  function automatic exp_t mdecode();
    exp_t e;
    int op;
    logic [15:0] w;
    w  = bi.inst;
    op = int'(w[15:11]);
    if (!bi.inst_valid) return BUB;
    e.op = w[15:11]; e.rd = w[10:8]; e.v = 1'b1; e.a = 16'h0; e.b = 16'h0;
    if (op == 0 || op == 1) e.a = mread(int'(w[7:5]));
    else if (op == 4 || (op >= 8 && op <= 14) || (op >= 16 && op <= 19)) begin
      e.a = mread(int'(w[7:5])); e.b = mread(int'(w[4:2]));
    end else if (op == 20 || op == 21) begin
      e.a = mread(int'(w[7:5])); e.b = 16'(w[4:0]);
    end else if (op == 22 || op == 23 || op == 5) begin
      e.a = 16'(w[7:4]); e.b = 16'(w[3:0]);
    end else if (op == 6) e.b = 16'(w[7:0]);
    else return BUB;
    return e;
  endfunction

  // Model the coming edge from the current inputs, queue the expectation, clock.
  task automatic step(input string nm);
    if (RST) begin
      cur = BUB;
      for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    end else begin
      if (bi.flush) cur = BUB;
      else if (!bi.stall) cur = mdecode();
      if (bi.wb_en && bi.wb_addr != 3'd0) mregs[bi.wb_addr] = bi.wb_data;
    end
    expq.push_back(cur);
    nmq.push_back(nm);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bi.inst_valid = 0; bi.inst = 16'h0; bi.stall = 0; bi.flush = 0;
    bi.wb_en = 0; bi.wb_addr = 0; bi.wb_data = 0;
    bi.ex_regwr = 0; bi.ex_rd = 0; bi.ex_result = 0; RST = 0;
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 2'b00};
  endfunction

  function automatic logic [15:0] mki(input logic [4:0] op, input logic [2:0] rd,
                                      input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  always @(negedge CLK) begin
    if (expq.size() > 0) begin
      exp_t e;
      exp_t g;
      string n;
      e = expq.pop_front();
      n = nmq.pop_front();
      g = '{op: bi.ALUControl, a: bi.SrcA, b: bi.SrcB, rd: bi.rd_out, v: bi.out_valid};
      compared++;
      if (g !== e) begin
        mismatched++;
        $display("FAIL %s: got op=%b A=%h B=%h rd=%0d v=%b, expected op=%b A=%h B=%h rd=%0d v=%b",
                 n, g.op, g.a, g.b, g.rd, g.v, e.op, e.a, e.b, e.rd, e.v);
      end
    end
  end

  initial begin
    logic [4:0] legal [18];
    legal = '{5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12,
              5'd14, 5'd16, 5'd17, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};
    cur = BUB;
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
    idle();
    #1;

    // T1: reset dominates a concurrent WB write
    RST = 1; bi.wb_en = 1; bi.wb_addr = 3'd5; bi.wb_data = 16'hBEEF;
    bi.inst_valid = 1; bi.inst = mk(5'b10000, 3'd1, 3'd5, 3'd5);
    step("t1_reset0");
    step("t1_reset1");
    idle();
    for (int r = 1; r < 8; r++) begin
      bi.inst_valid = 1; bi.inst = mk(5'b00100, 3'(r), 3'(r), 3'(r));
      step("t1_regs_zero");
    end

    // T2: WB then read
    idle(); bi.wb_en = 1; bi.wb_addr = 3'd3; bi.wb_data = 16'h1234;
    step("t2_write");
    idle(); bi.inst_valid = 1; bi.inst = mk(5'b10000, 3'd1, 3'd3, 3'd0);
    step("t2_add");

    // T3: bypass priority EX > WB > array
    idle(); bi.wb_en = 1; bi.wb_addr = 3'd2; bi.wb_data = 16'h0005;
    step("t3_seed");
    bi.wb_data = 16'h0007; bi.ex_regwr = 1; bi.ex_rd = 3'd2; bi.ex_result = 16'h0009;
    bi.inst_valid = 1; bi.inst = mk(5'b10010, 3'd4, 3'd2, 3'd2);
    step("t3_ex_wins");
    bi.ex_regwr = 0;
    step("t3_wb_wins");

    // T4: immediates
    idle(); bi.inst_valid = 1;
    bi.inst = mki(5'b00110, 3'd6, 8'hA5); step("t4_mov");
    bi.inst = mki(5'b00101, 3'd0, 8'h3C); step("t4_jump");
    bi.inst = mk(5'b10100, 3'd2, 3'd3, 3'd7) | 16'h0003; step("t4_addi");
    bi.inst = mki(5'b10111, 3'd7, 8'hF1); step("t4_subii");

    // T5: stall freezes, flush beats stall
    bi.inst = mk(5'b01000, 3'd5, 3'd3, 3'd2); step("t5_load_and");
    bi.stall = 1;
    for (int i = 0; i < 3; i++) begin
      bi.inst = 16'($urandom);
      bi.wb_en = 1; bi.wb_addr = 3'd3; bi.wb_data = 16'(16'h4000 + i);
      bi.ex_regwr = 1; bi.ex_rd = 3'd3; bi.ex_result = 16'hDEAD;
      step("t5_stall_hold");
    end
    idle(); bi.inst_valid = 1; bi.inst = mk(5'b10000, 3'd1, 3'd3, 3'd0);
    step("t5_wb_during_stall");
    bi.stall = 1; bi.flush = 1; step("t5_stall_flush");
    bi.stall = 0; bi.flush = 0; bi.inst_valid = 0; step("t5_invalid_bubble");

    // T6: R0 and illegal opcode
    idle(); bi.wb_en = 1; bi.wb_addr = 3'd0; bi.wb_data = 16'hFFFF;
    bi.inst_valid = 1; bi.inst = mk(5'b10000, 3'd1, 3'd0, 3'd0);
    step("t6_r0_fwd");
    idle(); bi.inst_valid = 1; bi.inst = mk(5'b10000, 3'd1, 3'd0, 3'd0);
    step("t6_r0_read");
    bi.inst = mk(5'b11111, 3'd3, 3'd3, 3'd3); step("t6_illegal");
    bi.inst = mk(5'b00010, 3'd3, 3'd3, 3'd3); step("t6_illegal2");

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if ($urandom_range(0, 9) < 8) w[15:11] = legal[$urandom_range(0, 17)];
      bi.inst       = w;
      bi.inst_valid = ($urandom_range(0, 9) < 8);
      bi.stall      = ($urandom_range(0, 9) < 2);
      bi.flush      = ($urandom_range(0, 19) == 0);
      bi.wb_en      = ($urandom_range(0, 1) == 1);
      bi.wb_addr    = 3'($urandom);
      bi.wb_data    = 16'($urandom);
      bi.ex_regwr   = ($urandom_range(0, 2) == 0);
      bi.ex_rd      = 3'($urandom);
      bi.ex_result  = 16'($urandom);
      RST           = ($urandom_range(0, 199) == 0);
      step("random");
    end

    idle();
    for (int i = 0; i < 4 && expq.size() > 0; i++) @(negedge CLK);
    #1;
    if (expq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
